// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state and phase encodings for the button conditioner
package button_conditioner_pkg;

    // Debounce FSM states
    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_VERIFY = 1'b1;

    // Auto-repeat phases: waiting for the first repeat, or for subsequent ones
    localparam logic [0:0] PH_FIRST  = 1'b0;
    localparam logic [0:0] PH_NEXT   = 1'b1;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - pin-side and event-side signal bundle for the button conditioner
interface button_conditioner_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] repeat_en;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rpt;

    // Driver side: raw inputs and repeat enables in, conditioned levels and events back
    modport master (
        output din,
        output repeat_en,
        input  dout,
        input  rise,
        input  fall,
        input  rpt
    );

    // Conditioner side
    modport slave (
        input  din,
        input  repeat_en,
        output dout,
        output rise,
        output fall,
        output rpt
    );
endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one channel: synchroniser, debounce FSM, edge pulses and auto-repeat
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int   CLOCKS       = 256,
    parameter int   CLOCKS_CLOG2 = 8,
    parameter logic INIT_BIT     = 1'b0,
    parameter int   REPEAT_DELAY = 24,
    parameter int   REPEAT_RATE  = 6,
    parameter int   REPEAT_CLOG2 = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic repeat_en,
    input  logic tick,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam logic [CLOCKS_CLOG2-1:0] CNT_LAST   = CLOCKS_CLOG2'(CLOCKS - 1);
    localparam logic [REPEAT_CLOG2-1:0] DELAY_LAST = REPEAT_CLOG2'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_CLOG2-1:0] RATE_LAST  = REPEAT_CLOG2'(REPEAT_RATE - 1);

    logic                    sync_q1;
    logic                    sync_q2;
    logic [0:0]              state;
    logic [CLOCKS_CLOG2-1:0] count;
    logic                    accept;
    logic [REPEAT_CLOG2-1:0] hold;
    logic [0:0]              phase;
    logic [REPEAT_CLOG2-1:0] hold_last;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= INIT_BIT;
            sync_q2 <= INIT_BIT;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // A new level is accepted on this edge; used to hold off repeat when dout is about to change
    always_comb begin
        accept    = (state == ST_VERIFY) && (sync_q2 != dout) && (count == CNT_LAST);
        hold_last = (phase == PH_FIRST) ? DELAY_LAST : RATE_LAST;
    end

    // Debounce FSM: a differing level must persist for CLOCKS cycles; any return to dout aborts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
            count <= '0;
            dout  <= INIT_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sync_q2 != dout) begin
                        count <= '0;
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (sync_q2 == dout) begin
                        state <= ST_STABLE;
                    end else if (count == CNT_LAST) begin
                        dout  <= sync_q2;
                        rise  <= sync_q2;
                        fall  <= ~sync_q2;
                        state <= ST_STABLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= ST_STABLE;
            endcase
        end
    end

    // Auto-repeat: count prescaler ticks while held and enabled, long gap first then shorter ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold  <= '0;
            phase <= PH_FIRST;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (!dout || !repeat_en || accept) begin
                hold  <= '0;
                phase <= PH_FIRST;
            end else if (tick) begin
                if (hold == hold_last) begin
                    rpt   <= 1'b1;
                    hold  <= '0;
                    phase <= PH_NEXT;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel debouncer with press/release events and auto-repeat
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               CLOCKS       = 256,
    parameter int               CLOCKS_CLOG2 = 8,
    parameter logic [WIDTH-1:0] INIT         = {WIDTH{1'b0}},
    parameter int               TICK_DIV     = 65536,
    parameter int               TICK_CLOG2   = 16,
    parameter int               REPEAT_DELAY = 24,
    parameter int               REPEAT_RATE  = 6,
    parameter int               REPEAT_CLOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    localparam logic [TICK_CLOG2-1:0] PRESC_LAST = TICK_CLOG2'(TICK_DIV - 1);

    logic [TICK_CLOG2-1:0] presc;
    logic                  tick;
    logic [WIDTH-1:0]      dout_v;
    logic [WIDTH-1:0]      rise_v;
    logic [WIDTH-1:0]      fall_v;
    logic [WIDTH-1:0]      rpt_v;

    // Shared free-running prescaler; channels see its wrap as the repeat tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == PRESC_LAST);

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        button_channel #(
            .CLOCKS       (CLOCKS),
            .CLOCKS_CLOG2 (CLOCKS_CLOG2),
            .INIT_BIT     (INIT[g]),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_CLOG2 (REPEAT_CLOG2)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (bus.din[g]),
            .repeat_en (bus.repeat_en[g]),
            .tick      (tick),
            .dout      (dout_v[g]),
            .rise      (rise_v[g]),
            .fall      (fall_v[g]),
            .rpt       (rpt_v[g])
        );
    end

    assign bus.dout = dout_v;
    assign bus.rise = rise_v;
    assign bus.fall = fall_v;
    assign bus.rpt  = rpt_v;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    logic seen;

    always #5 clk = ~clk;

    button_conditioner_if #(.WIDTH(2)) bus_a ();
    button_conditioner_if #(.WIDTH(2)) bus_b ();

    button_conditioner #(
        .WIDTH(2), .CLOCKS(4), .CLOCKS_CLOG2(2), .INIT(2'b00),
        .TICK_DIV(4), .TICK_CLOG2(2), .REPEAT_DELAY(3), .REPEAT_RATE(2), .REPEAT_CLOG2(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    button_conditioner #(
        .WIDTH(2), .CLOCKS(4), .CLOCKS_CLOG2(2), .INIT(2'b11),
        .TICK_DIV(4), .TICK_CLOG2(2), .REPEAT_DELAY(3), .REPEAT_RATE(2), .REPEAT_CLOG2(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rpt1(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!bus_a.rpt[1] && cycles < 24);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus_a.din       = 2'b00;
        bus_a.repeat_en = 2'b00;
        bus_b.din       = 2'b11;
        bus_b.repeat_en = 2'b00;
        step(3);
        rst_n = 1'b1;

        // Idle after reset: both INIT values held, no pulses
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("idle_a", {bus_a.dout, bus_a.rise, bus_a.fall, bus_a.rpt}, 8'h00);
            chk("idle_b", {bus_b.dout, bus_b.rise, bus_b.fall, bus_b.rpt}, 8'hC0);
        end

        // Clean press on channel 0: accepted at edge k+6
        bus_a.din = 2'b01;
        step(6);
        chk("press_pre_dout", bus_a.dout, 2'b00);
        chk("press_pre_rise", bus_a.rise, 2'b00);
        step(1);
        chk("press_dout", bus_a.dout, 2'b01);
        chk("press_rise", bus_a.rise, 2'b01);
        chk("press_fall", bus_a.fall, 2'b00);
        step(1);
        chk("press_rise_1cyc", bus_a.rise, 2'b00);

        // Clean release on channel 0
        bus_a.din = 2'b00;
        step(6);
        chk("rel_pre_dout", bus_a.dout, 2'b01);
        step(1);
        chk("rel_fall", {bus_a.dout, bus_a.rise, bus_a.fall}, 6'b00_00_01);

        // Bouncing press: single-cycle highs are rejected
        for (int i = 0; i < 4; i++) begin
            bus_a.din = 2'b01;
            step(1);
            bus_a.din = 2'b00;
            step(1);
            chk("bounce_quiet", {bus_a.dout, bus_a.rise}, 4'b0000);
        end
        bus_a.din = 2'b01;
        step(6);
        chk("settle_pre", {bus_a.dout, bus_a.rise}, 4'b0000);
        step(1);
        chk("settle_rise", {bus_a.dout, bus_a.rise}, 4'b0101);
        bus_a.din = 2'b00;
        step(9);
        chk("ch0_back_low", bus_a.dout, 2'b00);

        // Held press with repeat on channel 1
        bus_a.repeat_en = 2'b10;
        bus_a.din       = 2'b10;
        step(7);
        chk("hold_rise", {bus_a.dout, bus_a.rise, bus_a.rpt}, 6'b10_10_00);
        wait_rpt1(n);
        chk("rpt_first_lo", 32'(n >= 9), 1);
        chk("rpt_first_hi", 32'(n <= 12), 1);
        chk("rpt_no_edge", {bus_a.rise, bus_a.fall}, 4'b0000);
        wait_rpt1(n);
        chk("rpt_second_gap", n, 8);
        wait_rpt1(n);
        chk("rpt_third_gap", n, 8);
        bus_a.din = 2'b00;
        step(7);
        chk("hold_fall", {bus_a.dout, bus_a.fall, bus_a.rpt}, 6'b00_10_00);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen = seen | bus_a.rpt[1];
        end
        chk("no_rpt_after_fall", seen, 1'b0);

        // Repeat enable dropped after first repeat, then restored
        bus_a.din = 2'b10;
        step(7);
        chk("hold2_rise", bus_a.rise, 2'b10);
        wait_rpt1(n);
        chk("rpt2_first_lo", 32'(n >= 9), 1);
        chk("rpt2_first_hi", 32'(n <= 12), 1);
        bus_a.repeat_en = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen = seen | bus_a.rpt[1];
        end
        chk("no_rpt_disabled", seen, 1'b0);
        bus_a.repeat_en = 2'b10;
        wait_rpt1(n);
        chk("rpt_reen_lo", 32'(n >= 9), 1);
        chk("rpt_reen_hi", 32'(n <= 12), 1);
        bus_a.din       = 2'b00;
        bus_a.repeat_en = 2'b00;
        step(10);
        chk("ch1_back_low", bus_a.dout, 2'b00);

        // Simultaneous press on both channels
        bus_a.din = 2'b11;
        step(7);
        chk("both_rise", {bus_a.dout, bus_a.rise}, 4'b1111);

        // Reset pulse while both channels verify a release
        bus_a.din = 2'b00;
        step(3);
        chk("mid_verify_dout", {bus_a.dout, bus_a.fall}, 4'b1100);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bus_a.dout, bus_a.rise, bus_a.fall, bus_a.rpt}, 8'h00);
        bus_a.din = 2'b11;
        step(2);
        chk("in_rst", bus_a.dout, 2'b00);
        rst_n = 1'b1;
        step(6);
        chk("post_rst_pre", {bus_a.dout, bus_a.rise}, 4'b0000);
        step(1);
        chk("post_rst_rise", {bus_a.dout, bus_a.rise}, 4'b1111);
        step(1);
        chk("post_rst_rise_1cyc", bus_a.rise, 2'b00);
        chk("b_after_rst", {bus_b.dout, bus_b.rise, bus_b.fall, bus_b.rpt}, 8'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel input conditioner for pushbuttons and other slow, bouncy external inputs. It synchronises each input to `clk`, debounces it with a per-channel stability counter, and emits one-cycle press/release event pulses. An optional per-channel auto-repeat pulse train fires while an input is held. It sits between the board pins and joypad/UI logic and replaces the plain level debouncer wherever edge events or repeat are needed.

## Interface
- `WIDTH`, 8: number of independent channels.
- `CLOCKS`, 256: stable cycles required before a level is accepted; must be ≥2.
- `CLOCKS_CLOG2`, 8: counter width; must satisfy 2^CLOCKS_CLOG2 ≥ CLOCKS.
- `INIT`, {WIDTH{1'b0}}: reset value of synchronisers and `dout`, per bit.
- `TICK_DIV`, 65536: repeat prescaler period in `clk` cycles; must be ≥1.
- `TICK_CLOG2`, 16: prescaler width; must satisfy 2^TICK_CLOG2 ≥ TICK_DIV.
- `REPEAT_DELAY`, 24: ticks from accepted press to first repeat; must be ≥1.
- `REPEAT_RATE`, 6: ticks between subsequent repeats; must be ≥1.
- `REPEAT_CLOG2`, 5: hold-counter width; must cover max(REPEAT_DELAY, REPEAT_RATE).
- `clk`, in, 1: single clock; every register is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, WIDTH: raw asynchronous inputs.
- `repeat_en`, in, WIDTH: per-channel auto-repeat enable; synchronous to `clk`.
- `dout`, out, WIDTH: debounced level. Resets to `INIT`.
- `rise`, out, WIDTH: one-cycle pulse when `dout[i]` goes 0→1. Resets to 0.
- `fall`, out, WIDTH: one-cycle pulse when `dout[i]` goes 1→0. Resets to 0.
- `rpt`, out, WIDTH: one-cycle auto-repeat pulse. Resets to 0.

## Operation
- **Sync:** two-flop synchroniser per bit, reset to `INIT[i]`. `s[i]` denotes the second stage.
- **Channel FSM, STABLE (reset state):**
  - If `s[i] != dout[i]`: count←0 and go to VERIFY.
- **Channel FSM, VERIFY:**
  - If `s[i] == dout[i]`: return to STABLE. This rejects the glitch; no pulse and no `dout` change.
  - Else if count == CLOCKS-1: `dout[i]`←`s[i]`, go to STABLE, and assert `rise[i]` or `fall[i]` on the same edge.
  - Else: count←count+1.
- The counter never wraps; it saturates at CLOCKS-1 by construction.
- **Prescaler:** a single free-running counter shared by all channels, running 0..TICK_DIV-1 from reset. `tick` is a one-cycle strobe when the counter is at TICK_DIV-1.
- **Repeat, per channel:**
  - The hold counter and phase (FIRST/NEXT) are cleared whenever `dout[i]`=0, `repeat_en[i]`=0, or `rise[i]`=1.
  - Otherwise the hold counter increments on each `tick`.
  - On the tick where it reaches REPEAT_DELAY (FIRST) or REPEAT_RATE (NEXT): `rpt[i]` is asserted, the counter←0, and the phase←NEXT.
- The first repeat lands between (REPEAT_DELAY-1)·TICK_DIV+1 and REPEAT_DELAY·TICK_DIV cycles after `rise`. This jitter from the free-running prescaler is intended.
- `rpt` never asserts in the same cycle as `rise` or `fall` for the same channel.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Let `din[i]` hold a new value from before edge k and stay there. Then `s[i]` updates at edge k+1, VERIFY is entered at edge k+2, and `dout[i]`/pulse update at edge k+2+CLOCKS.
- Any bounce during VERIFY restarts the full CLOCKS window once the input settles again.
- `rise`, `fall` and `rpt` are registered outputs, high for exactly one cycle.
- Reset asserted mid-operation immediately forces all outputs and state to their reset values:
  - `dout`=`INIT`, pulses 0, FSM STABLE, prescaler 0.
- On reset release no pulse is generated unless `din` differs from `INIT`. If it differs, the normal debounce timing applies.

## Structure
- A shared package or header holds the FSM state encoding (STABLE, VERIFY) and the repeat phase encoding (FIRST, NEXT).
- Sub-module `button_channel`: synchroniser, debounce FSM, edge pulses and repeat logic for one bit. It takes `tick` as an input.
- The top level instantiates `button_channel` WIDTH times via generate and owns the single prescaler.

## Test plan
Bench configuration: WIDTH=2, CLOCKS=4, INIT=2'b00, TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2.

- Reset with `din`=00 → `dout`=00 and no pulses for 50 cycles. Repeat with INIT=2'b11 and `din`=11 → `dout`=11 and no pulses.
- `din[0]` 0→1 before edge k and held → `dout[0]`=1 and a single-cycle `rise[0]` at edge k+6; `fall` stays 0.
- `din[0]` toggles 1→0→1 with 1-cycle highs repeatedly, then settles high → no `dout` change during the bounces; `rise[0]` fires 6 edges after the final settle.
- `din[1]` high held for 40 cycles with `repeat_en[1]`=1 → `rise[1]` once; first `rpt[1]` 9–12 cycles after `rise`, then every 8 cycles. Release → `fall[1]` and no further `rpt`.
- Same hold with `repeat_en[1]` dropped after the first `rpt` → no further `rpt`. Re-enable → the next `rpt` comes after REPEAT_DELAY ticks again.
- Both channels change on the same edge, then `rst_n` pulses low mid-VERIFY → on the change, both `rise` bits assert in the same cycle. After the reset pulse: `dout`=00 immediately, and channels re-debounce from STABLE after release.
